set_array_ctrl: RTL and testbench
=================================

# set_array_ctrl

Sequencing and arbitration front-end for the cache set array SRAM. Two requesters share the single SRAM port: requester 0 is the pipeline lookup/update path and requester 1 is the refill/maintenance path. The block grants at most one access per cycle, registers read data for the winner, and optionally clears the entire array after reset so every valid bit starts at 0. It sits between the cache controller logic and the set array instance, and drives every SRAM control pin.

## Interface
- CACHE_ADDR_WIDTH, 9, set index width; the array holds 2**CACHE_ADDR_WIDTH sets
- SET_SIZE, 111, width of one set word in bits
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous reset, active-low
- rN_req  in  1  requester N (N = 0, 1) wants an access; held with its fields until granted
- rN_we  in  1  1 = write, 0 = read
- rN_addr  in  CACHE_ADDR_WIDTH  set index
- rN_wd  in  SET_SIZE  write data; ignored for reads
- rN_gnt  out  1  combinational; the access is accepted this cycle
- rN_rvalid  out  1  registered; rdata holds requester N's read result
- rdata  out  SET_SIZE  registered read data, shared by both requesters
- init_done  out  1  registered; array is ready for requests
- sram_addr  out  CACHE_ADDR_WIDTH  SRAM address
- sram_wd  out  SET_SIZE  SRAM write data
- sram_we  out  1  SRAM write enable
- sram_re  out  1  SRAM read enable
- sram_rd  in  SET_SIZE  SRAM read data; combinational in the same cycle as sram_re

## Operation
- States: BOOT (reset value), SWEEP (present only with the macro), RUN.
- BOOT: no grants and no SRAM access. On the first clock edge after rst_n rises, go to SWEEP if the macro is defined, otherwise to RUN.
- SWEEP: a counter named sweep_idx starts at 0. Each cycle drive sram_we=1, sram_wd=0 and sram_addr=sweep_idx, then increment sweep_idx. After writing index 2**CACHE_ADDR_WIDTH-1, go to RUN. No grants are issued in this state.
- RUN arbitration, one grant per cycle:
  - Only one requester asserts req: that requester is granted.
  - Both assert req: the requester not granted most recently wins (round-robin). The last-winner pointer resets to 1, so requester 0 wins the first tie.
  - The pointer updates only when a grant is issued.
- A granted write drives sram_we=1 with the winner's addr and wd.
- A granted read drives sram_re=1. sram_rd is captured into rdata at the same clock edge.
- When no access is granted, sram_we=0 and sram_re=0. sram_addr and sram_wd are then don't-care, but are driven to 0.
- A requester must hold req, we, addr and wd stable until it sees gnt. It may drop req or present a new request in the cycle after gnt.
- rdata holds its value until the next granted read.

## Timing
- Reset values: rN_rvalid=0, rdata=0, init_done=0, state=BOOT, sweep_idx=0, last-winner=1.
- While in BOOT or SWEEP, rN_gnt=0 and sram_re=0.
- Read latency: gnt in cycle N, then rN_rvalid=1 and rdata valid in cycle N+1. rvalid is a single-cycle pulse per grant.
- Write: gnt in cycle N, and the SRAM is updated at the end of cycle N. A read granted in N+1 to the same address returns the new data.
- Back-to-back throughput is one access per cycle with no bubbles.
- init_done rises in the cycle the state becomes RUN:
  - with the macro: 2**CACHE_ADDR_WIDTH+1 cycles after reset release;
  - without it: 1 cycle after reset release.
- Reset asserted mid-sweep or mid-read: everything returns to reset values immediately. A pending rvalid is lost, and a new sweep starts from index 0.
- Simultaneous read by one requester and write by the other: only the winner proceeds. The loser keeps req high and is served the next cycle.

## Configuration
- SET_ARRAY_CTRL_INIT_SWEEP_EN
  - Defined: the SWEEP state and the sweep_idx counter exist, and the whole array is zeroed after every reset.
  - Undefined: the SWEEP state and counter are not built, and BOOT goes directly to RUN. Array contents after reset are then undefined, and clearing them is the responsibility of other logic.

## Test plan
- Sweep, with the macro, CACHE_ADDR_WIDTH=4: release reset → sram_we=1 with addr 0..15 and wd=0 on 16 consecutive cycles; gnt=0 throughout; init_done=1 at cycle 17; every set reads back 0.
- No sweep, without the macro: release reset → init_done=1 after 1 cycle; r0 write to addr 3 is granted in that cycle.
- Write then read: r0 writes 0x5A at addr 7 in cycle N, then reads addr 7 in N+1 → r0_rvalid=1 and rdata=0x5A in N+2; r1_rvalid stays 0.
- Contention: both requesters hold reads for 4 cycles starting right after init → grants go r0, r1, r0, r1; rvalid alternates to match on the following cycles.
- Single requester streaming: r1 reads addr 0..7 on 8 consecutive cycles → 8 grants with no bubbles; rdata follows one cycle behind.
- Mid-sweep reset: assert rst_n low at sweep_idx=9 → all outputs return to reset values; after release the sweep restarts at addr 0.

Source files
------------

// File: rtl/set_array_ctrl.sv
// set_array_ctrl: arbitration and sequencing front-end for the cache set array SRAM.
// Requester 0 (pipeline) and requester 1 (refill/maintenance) share the single SRAM
// port with round-robin arbitration on ties. Read data is registered one cycle after grant.
// Optional feature macro: SET_ARRAY_CTRL_INIT_SWEEP_EN -- when defined, the whole array
// is written to zero after every reset before any request is accepted.
module set_array_ctrl #(
    parameter int CACHE_ADDR_WIDTH = 9,
    parameter int SET_SIZE         = 111
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        r0_req,
    input  logic                        r0_we,
    input  logic [CACHE_ADDR_WIDTH-1:0] r0_addr,
    input  logic [SET_SIZE-1:0]         r0_wd,
    output logic                        r0_gnt,
    output logic                        r0_rvalid,
    input  logic                        r1_req,
    input  logic                        r1_we,
    input  logic [CACHE_ADDR_WIDTH-1:0] r1_addr,
    input  logic [SET_SIZE-1:0]         r1_wd,
    output logic                        r1_gnt,
    output logic                        r1_rvalid,
    output logic [SET_SIZE-1:0]         rdata,
    output logic                        init_done,
    output logic [CACHE_ADDR_WIDTH-1:0] sram_addr,
    output logic [SET_SIZE-1:0]         sram_wd,
    output logic                        sram_we,
    output logic                        sram_re,
    input  logic [SET_SIZE-1:0]         sram_rd
);

`ifdef SET_ARRAY_CTRL_INIT_SWEEP_EN
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        SWEEP = 2'd1,
        RUN   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd2
    } state_t;
`endif

    state_t state;
    logic   last_winner;
    logic   in_run;

`ifdef SET_ARRAY_CTRL_INIT_SWEEP_EN
    logic [CACHE_ADDR_WIDTH-1:0] sweep_idx;
`endif

    assign in_run = (state == RUN);

    // A lone requester always wins; on a tie the requester that did not win last time goes.
    assign r0_gnt = in_run & r0_req & (~r1_req | last_winner);
    assign r1_gnt = in_run & r1_req & (~r0_req | ~last_winner);

    // SRAM pins follow the granted requester, or the sweep counter while clearing the array.
    always_comb begin
        sram_addr = '0;
        sram_wd   = '0;
        sram_we   = 1'b0;
        sram_re   = 1'b0;
        if (r0_gnt) begin
            sram_addr = r0_addr;
            sram_wd   = r0_we ? r0_wd : '0;
            sram_we   = r0_we;
            sram_re   = ~r0_we;
        end else if (r1_gnt) begin
            sram_addr = r1_addr;
            sram_wd   = r1_we ? r1_wd : '0;
            sram_we   = r1_we;
            sram_re   = ~r1_we;
`ifdef SET_ARRAY_CTRL_INIT_SWEEP_EN
        end else if (state == SWEEP) begin
            sram_addr = sweep_idx;
            sram_we   = 1'b1;
`endif
        end
    end

    // Sequencer: leave BOOT after reset, optionally clear the array, then arbitrate in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            init_done   <= 1'b0;
            last_winner <= 1'b1;
`ifdef SET_ARRAY_CTRL_INIT_SWEEP_EN
            sweep_idx   <= '0;
`endif
        end else begin
            case (state)
                BOOT: begin
`ifdef SET_ARRAY_CTRL_INIT_SWEEP_EN
                    state     <= SWEEP;
                    sweep_idx <= '0;
`else
                    state     <= RUN;
                    init_done <= 1'b1;
`endif
                end
`ifdef SET_ARRAY_CTRL_INIT_SWEEP_EN
                SWEEP: begin
                    sweep_idx <= sweep_idx + 1'b1;
                    if (sweep_idx == {CACHE_ADDR_WIDTH{1'b1}}) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
`endif
                RUN: begin
                    if (r0_gnt) begin
                        last_winner <= 1'b0;
                    end else if (r1_gnt) begin
                        last_winner <= 1'b1;
                    end
                end
                default: begin
                    state     <= BOOT;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    // Capture read data at the grant edge and pulse the owner's rvalid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            rdata     <= '0;
        end else begin
            r0_rvalid <= r0_gnt & ~r0_we;
            r1_rvalid <= r1_gnt & ~r1_we;
            if ((r0_gnt & ~r0_we) | (r1_gnt & ~r1_we)) begin
                rdata <= sram_rd;
            end
        end
    end

endmodule

// File: tb/tb_set_array_ctrl.sv
// tb_set_array_ctrl: randomized scoreboard bench for set_array_ctrl.
// A behavioural reference (array contents, round-robin pointer) predicts grants and
// read results; a separate monitor pops expected reads whenever an rvalid appears.
module tb_set_array_ctrl;

    localparam int AW    = 4;
    localparam int SW    = 111;
    localparam int DEPTH = 1 << AW;
`ifdef SET_ARRAY_CTRL_INIT_SWEEP_EN
    localparam int EXP_INIT = DEPTH + 1;
`else
    localparam int EXP_INIT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [SW-1:0] r0_wd, r1_wd;
    logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, init_done;
    logic [SW-1:0] rdata, sram_wd, sram_rd;
    logic [AW-1:0] sram_addr;
    logic          sram_we, sram_re;

    always #5 clk = ~clk;

    set_array_ctrl #(.CACHE_ADDR_WIDTH(AW), .SET_SIZE(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wd(r0_wd),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wd(r1_wd),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
        .rdata(rdata), .init_done(init_done),
        .sram_addr(sram_addr), .sram_wd(sram_wd), .sram_we(sram_we), .sram_re(sram_re),
        .sram_rd(sram_rd)
    );

    // SRAM model: combinational read, write at the clock edge, preloadable with garbage.
    logic [SW-1:0] mem [DEPTH];
    logic [SW-1:0] preload [DEPTH];
    logic          preload_en = 1'b0;
    assign sram_rd = mem[sram_addr];
    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= preload[i];
        end else if (sram_we) begin
            mem[sram_addr] <= sram_wd;
        end
    end

    // Reference model state
    typedef struct {
        int            id;
        logic [SW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t          exp_q[$];
    logic [SW-1:0] ref_mem [DEPTH];
    int            last_win;
    logic          p_req [2];
    logic          p_we  [2];
    logic [AW-1:0] p_addr[2];
    logic [SW-1:0] p_wd  [2];

    int            cycle = 0;
    int            checks = 0;
    int            errors = 0;
    logic [SW-1:0] last_rd = '0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [SW-1:0] rand_word();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[SW-1:0];
    endfunction

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%b expected=%b (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic checkOutput(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic drive_inputs();
        r0_req  = p_req[0];  r0_we = p_we[0];  r0_addr = p_addr[0];  r0_wd = p_wd[0];
        r1_req  = p_req[1];  r1_we = p_we[1];  r1_addr = p_addr[1];  r1_wd = p_wd[1];
    endtask

    task automatic set_req(input int k, input logic we, input logic [AW-1:0] addr, input logic [SW-1:0] wd);
        p_req[k] = 1'b1;  p_we[k] = we;  p_addr[k] = addr;  p_wd[k] = wd;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < 2; k++) begin
            p_req[k] = 1'b0;  p_we[k] = 1'b0;  p_addr[k] = '0;  p_wd[k] = '0;
        end
    endtask

    task automatic finish_sim();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // One cycle: present pending requests, predict the winner, check pins, update the model.
    task automatic applyStimulus();
        int win;
        @(posedge clk);
        #1;
        drive_inputs();
        @(negedge clk);
        win = -1;
        if (p_req[0] && p_req[1]) win = (last_win == 0) ? 1 : 0;
        else if (p_req[0])        win = 0;
        else if (p_req[1])        win = 1;
        checkBit("gnt0", r0_gnt, win == 0);
        checkBit("gnt1", r1_gnt, win == 1);
        if (win >= 0) begin
            if (p_we[win]) begin
                checkBit("wr_we", sram_we, 1'b1);
                checkOutput("wr_addr", SW'(sram_addr), SW'(p_addr[win]));
                checkOutput("wr_data", sram_wd, p_wd[win]);
                ref_mem[p_addr[win]] = p_wd[win];
            end else begin
                checkBit("rd_re", sram_re, 1'b1);
                exp_q.push_back('{win, ref_mem[p_addr[win]], cycle});
            end
            last_win   = win;
            p_req[win] = 1'b0;
        end else begin
            checkBit("idle_we", sram_we, 1'b0);
            checkBit("idle_re", sram_re, 1'b0);
        end
    endtask

    // Release reset and follow BOOT (and SWEEP) up to the first RUN cycle; abort_c >= 0
    // re-asserts reset at that cycle count after release.
    task automatic do_boot(input int abort_c, output bit ok);
        int c;
        ok = 1'b0;
        last_win = 1;
        clear_reqs();
        set_req(0, 1'b1, AW'(3), rand_word());
        drive_inputs();
`ifdef SET_ARRAY_CTRL_INIT_SWEEP_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        c = 0;
        while (1) begin
            @(negedge clk);
            if (init_done) break;
            checkBit("boot_gnt0", r0_gnt, 1'b0);
            checkBit("boot_re", sram_re, 1'b0);
`ifdef SET_ARRAY_CTRL_INIT_SWEEP_EN
            checkBit("sweep_we", sram_we, (c >= 1) && (c <= DEPTH));
            if ((c >= 1) && (c <= DEPTH)) begin
                checkOutput("sweep_addr", SW'(sram_addr), SW'(c - 1));
                checkOutput("sweep_wd", sram_wd, '0);
            end
`else
            checkBit("boot_we", sram_we, 1'b0);
`endif
            if (c == abort_c) begin
                #1;
                rst_n = 1'b0;
                #1;
                checkBit("abort_init_done", init_done, 1'b0);
                checkBit("abort_we", sram_we, 1'b0);
                checkBit("abort_gnt0", r0_gnt, 1'b0);
                checkBit("abort_rvalid0", r0_rvalid, 1'b0);
                checkOutput("abort_rdata", rdata, '0);
                return;
            end
            if (c > DEPTH + 4) begin
                checkBit("boot_timeout", init_done, 1'b1);
                return;
            end
            @(posedge clk);
            c++;
        end
        checkOutput("init_latency", SW'(c), SW'(EXP_INIT));
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                checkOutput("mem_image", mem[i], ref_mem[i]);
                break;
            end
        end
        checkBit("init_gnt0", r0_gnt, 1'b1);
        checkBit("init_we", sram_we, 1'b1);
        checkOutput("init_addr", SW'(sram_addr), SW'(3));
        ref_mem[3] = p_wd[0];
        last_win   = 0;
        p_req[0]   = 1'b0;
        ok = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 6 && (p_req[0] || p_req[1]); i++) applyStimulus();
        applyStimulus();
        applyStimulus();
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!p_req[k] && ($urandom_range(0, 1) == 1))
                    set_req(k, 1'(($urandom_range(0, 2)) == 0), AW'($urandom_range(0, DEPTH - 1)), rand_word());
            end
            applyStimulus();
        end
    endtask

    // Monitor: every rvalid must match the oldest expected read, granted exactly one cycle earlier.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkBit("rst_rvalid0", r0_rvalid, 1'b0);
            checkBit("rst_rvalid1", r1_rvalid, 1'b0);
            checkOutput("rst_rdata", rdata, '0);
            last_rd = '0;
        end else if (r0_rvalid || r1_rvalid) begin
            checkBit("rvalid_onehot", r0_rvalid & r1_rvalid, 1'b0);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL rvalid_unexpected actual=%b%b expected=00 (cycle %0d)", r0_rvalid, r1_rvalid, cycle);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkBit("rvalid_owner", r1_rvalid, e.id == 1);
                checkOutput("rd_data", rdata, e.data);
                checkOutput("rd_latency", SW'(cycle - e.cyc), SW'(1));
                last_rd = e.data;
            end
        end else begin
            checkOutput("rdata_hold", rdata, last_rd);
        end
    end

    initial begin
        bit ok;
        for (int i = 0; i < DEPTH; i++) begin
            preload[i] = rand_word();
            ref_mem[i] = preload[i];
        end
        clear_reqs();
        set_req(0, 1'b0, AW'(0), '0);
        drive_inputs();
        preload_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        preload_en = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkBit("rst_init_done", init_done, 1'b0);
        checkBit("rst_gnt0", r0_gnt, 1'b0);
        checkBit("rst_re", sram_re, 1'b0);
        checkBit("rst_we", sram_we, 1'b0);

`ifdef SET_ARRAY_CTRL_INIT_SWEEP_EN
        $display("[TB] sweep interrupted by reset at index 9");
        do_boot(10, ok);
        repeat (2) @(negedge clk);
`endif
        do_boot(-1, ok);
        if (!ok) finish_sim();

        $display("[TB] write then read");
        set_req(0, 1'b1, AW'(7), SW'(8'h5A));
        applyStimulus();
        set_req(0, 1'b0, AW'(7), '0);
        applyStimulus();
        applyStimulus();

        $display("[TB] contention");
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++)
                if (!p_req[k]) set_req(k, 1'b0, AW'($urandom_range(0, DEPTH - 1)), '0);
            applyStimulus();
        end
        drain();

        $display("[TB] r1 streaming reads");
        for (int i = 0; i < 8; i++) begin
            set_req(1, 1'b0, AW'(i), '0);
            applyStimulus();
        end
        drain();

        $display("[TB] random traffic");
        random_phase(300);
        drain();

        $display("[TB] reset during a read");
        clear_reqs();
        set_req(0, 1'b0, AW'($urandom_range(0, DEPTH - 1)), '0);
        applyStimulus();
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        clear_reqs();
        drive_inputs();
        #1;
        checkBit("midread_gnt0", r0_gnt, 1'b0);
        repeat (2) @(negedge clk);
        do_boot(-1, ok);
        if (!ok) finish_sim();

        random_phase(100);
        drain();

        checkOutput("queue_empty", SW'(exp_q.size()), '0);
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                checkOutput("final_mem", mem[i], ref_mem[i]);
                break;
            end
        end
        finish_sim();
    end

endmodule
